// File: rtl/sub_serial_if.sv
// Operand/result bundle for the bit-serial subtractor: start request, operands, result and status.
interface sub_serial_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic             borrow_out;
    logic             busy;
    logic             done;

    modport master (
        output en, a, b,
        input  out, borrow_out, busy, done
    );

    modport slave (
        input  en, a, b,
        output out, borrow_out, busy, done
    );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial a-b, LSB first, borrow flop; WIDTH+2 cycles per op, start ignored while busy (no queuing).
// SUB_SERIAL_SCRAMBLE_EN: operands arrive scrambled and are XOR-descrambled when loaded.
module sub_serial #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    sub_serial_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             borrow;
    logic             borrow_reg;
    logic             diff;
    logic             borrow_nxt;
    logic             last;
    logic [CW-1:0]    count;

`ifdef SUB_SERIAL_SCRAMBLE_EN
    // The 8-bit masks tile across wider operands: mask bit i = MASK8[i mod 8].
    function automatic logic [WIDTH-1:0] tile_mask(input logic [7:0] m8);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = m8[3'(i % 8)];
        end
        return m;
    endfunction

    localparam logic [WIDTH-1:0] A_MASK = tile_mask(8'h6A);
    localparam logic [WIDTH-1:0] B_MASK = tile_mask(8'hD1);

    assign a_in = bus.a ^ A_MASK;
    assign b_in = bus.b ^ B_MASK;
`else
    assign a_in = bus.a;
    assign b_in = bus.b;
`endif

    assign diff       = a_reg[0] ^ b_reg[0] ^ borrow;
    assign borrow_nxt = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow);
    assign last       = (count == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.en) state_nxt = SUB;
            SUB:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            borrow     <= 1'b0;
            count      <= '0;
            out_reg    <= '0;
            borrow_reg <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        a_reg   <= a_in;
                        b_reg   <= b_in;
                        borrow  <= 1'b0;
                        count   <= '0;
                        out_reg <= '0;
                    end
                end
                SUB: begin
                    borrow  <= borrow_nxt;
                    out_reg <= {diff, out_reg[WIDTH-1:1]};
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    count   <= count + 1'b1;
                    // Final borrow is the one produced by the MSB step.
                    if (last) borrow_reg <= borrow_nxt;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.out        = out_reg;
    assign bus.borrow_out = borrow_reg;
    assign bus.busy       = (state == SUB) || (state == DONE);
    assign bus.done       = (state == DONE);
endmodule
